// File: rtl/fifo_word_reader.sv
// Read-domain consumer for cdc_fifo: packs consecutive FWFT bytes into little-endian words
// and hands them downstream on valid/ready, with a flush that emits a partial word.
module fifo_word_reader #(
    parameter int DATA_WIDTH     = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   read_empty,
    input  logic [DATA_WIDTH-1:0]                  read_data,
    output logic                                   read_next,
    input  logic                                   flush,
    output logic [DATA_WIDTH*BYTES_PER_WORD-1:0]   word_data,
    output logic [$clog2(BYTES_PER_WORD+1)-1:0]    word_bytes,
    output logic                                   word_valid,
    input  logic                                   word_ready,
    output logic                                   busy,
    output logic [COUNT_WIDTH-1:0]                 words_sent
);

    localparam int LW = $clog2(BYTES_PER_WORD + 1);
    localparam int WW = DATA_WIDTH * BYTES_PER_WORD;

    logic [BYTES_PER_WORD-1:0][DATA_WIDTH-1:0] acc_q, acc_d, masked;
    logic [LW-1:0]          lane_count_q, lane_count_d, wr_lane;
    logic                   flush_pending_q, flush_pending_d;
    logic                   word_valid_q, word_valid_d;
    logic [WW-1:0]          word_data_q, word_data_d;
    logic [LW-1:0]          word_bytes_q, word_bytes_d;
    logic [COUNT_WIDTH-1:0] words_sent_q, words_sent_d;

    logic slot_free, full, load, pop;

    assign slot_free = !word_valid_q || word_ready;
    assign full      = (lane_count_q == LW'(BYTES_PER_WORD));
    assign load      = slot_free && (full || (flush_pending_q && lane_count_q != '0));
    assign pop       = !reset && !read_empty && !flush_pending_q && (!full || load);
    assign wr_lane   = load ? '0 : lane_count_q;

    // A load and a pop may share a cycle: the new byte lands in lane 0 of the freshly cleared accumulator.
    always_comb begin
        acc_d           = acc_q;
        lane_count_d    = lane_count_q;
        flush_pending_d = flush_pending_q;
        word_valid_d    = word_valid_q;
        word_data_d     = word_data_q;
        word_bytes_d    = word_bytes_q;
        words_sent_d    = words_sent_q;
        masked          = '0;

        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (LW'(i) < lane_count_q) begin
                masked[i] = acc_q[i];
            end
        end

        if (word_valid_q && word_ready) begin
            word_valid_d = 1'b0;
            words_sent_d = words_sent_q + COUNT_WIDTH'(1);
        end

        if (flush && !flush_pending_q && lane_count_q != '0) begin
            flush_pending_d = 1'b1;
        end

        if (load) begin
            word_data_d     = masked;
            word_bytes_d    = lane_count_q;
            word_valid_d    = 1'b1;
            acc_d           = '0;
            lane_count_d    = '0;
            flush_pending_d = 1'b0;
        end

        if (pop) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                if (LW'(i) == wr_lane) begin
                    acc_d[i] = read_data;
                end
            end
            lane_count_d = wr_lane + LW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q           <= '0;
            lane_count_q    <= '0;
            flush_pending_q <= 1'b0;
            word_valid_q    <= 1'b0;
            word_data_q     <= '0;
            word_bytes_q    <= '0;
            words_sent_q    <= '0;
        end else begin
            acc_q           <= acc_d;
            lane_count_q    <= lane_count_d;
            flush_pending_q <= flush_pending_d;
            word_valid_q    <= word_valid_d;
            word_data_q     <= word_data_d;
            word_bytes_q    <= word_bytes_d;
            words_sent_q    <= words_sent_d;
        end
    end

    assign read_next  = pop;
    assign word_data  = word_data_q;
    assign word_bytes = word_bytes_q;
    assign word_valid = word_valid_q;
    assign words_sent = words_sent_q;
    assign busy       = (lane_count_q != '0) || word_valid_q || flush_pending_q;

endmodule

// File: tb/tb_fifo_word_reader.sv
// Bench for fifo_word_reader: a queue-based FIFO feeds the DUT and a byte-stream model
// predicts each word (groups of four bytes, little-endian; flush emits the leftover bytes).
module tb_fifo_word_reader;

    localparam int BPW = 4;

    logic        clock = 1'b0;
    logic        reset, read_empty, read_next, flush, word_valid, word_ready, busy;
    logic [7:0]  read_data;
    logic [31:0] word_data;
    logic [2:0]  word_bytes;
    logic [15:0] words_sent;

    logic        w_read_next, w_word_valid, w_busy;
    logic [31:0] w_word_data;
    logic [2:0]  w_word_bytes;
    logic [3:0]  w_words_sent;

    always #5 clock = ~clock;

    fifo_word_reader #(.DATA_WIDTH(8), .BYTES_PER_WORD(BPW), .COUNT_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .read_empty(read_empty), .read_data(read_data),
        .read_next(read_next), .flush(flush), .word_data(word_data), .word_bytes(word_bytes),
        .word_valid(word_valid), .word_ready(word_ready), .busy(busy), .words_sent(words_sent)
    );

    // Narrow-counter twin sharing every input; it behaves identically except for words_sent width.
    fifo_word_reader #(.DATA_WIDTH(8), .BYTES_PER_WORD(BPW), .COUNT_WIDTH(4)) dut_wrap (
        .clock(clock), .reset(reset), .read_empty(read_empty), .read_data(read_data),
        .read_next(w_read_next), .flush(flush), .word_data(w_word_data), .word_bytes(w_word_bytes),
        .word_valid(w_word_valid), .word_ready(word_ready), .busy(w_busy), .words_sent(w_words_sent)
    );

    typedef struct {
        logic [31:0] data;
        logic [2:0]  bytes;
    } word_t;

    logic [7:0] fifo_q[$];
    logic [7:0] pend_q[$];
    word_t      exp_q[$];

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;
    int pops = 0;
    int first_pop = -1;
    int last_pop = -1;
    int first_valid = -1;
    int exp_sent = 0;

    function automatic void refresh_fifo();
        read_empty = (fifo_q.size() == 0);
        read_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    endfunction

    function automatic void emit_pending();
        word_t w;
        w.data  = '0;
        w.bytes = 3'(pend_q.size());
        for (int i = 0; i < pend_q.size(); i++) w.data[8*i +: 8] = pend_q[i];
        exp_q.push_back(w);
        pend_q.delete();
    endfunction

    function automatic void push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        pend_q.push_back(b);
        if (pend_q.size() == BPW) emit_pending();
        refresh_fifo();
    endfunction

    function automatic void model_flush();
        if (pend_q.size() != 0) emit_pending();
    endfunction

    function automatic void model_reset();
        fifo_q.delete();
        pend_q.delete();
        exp_q.delete();
        exp_sent = 0;
        refresh_fifo();
    endfunction

    task automatic tick();
        word_t w;
        @(posedge clock);
        cycle++;
        if (read_next) begin
            pops++;
            last_pop = cycle;
            if (first_pop < 0) first_pop = cycle;
            vectors++;
            if (fifo_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL pop_on_empty: read_next=1, required 0 with FIFO empty");
            end else begin
                void'(fifo_q.pop_front());
            end
        end
        if (!reset && word_valid && word_ready) begin
            exp_sent++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_word: got %h/%0d, required no word", word_data, word_bytes);
            end else begin
                w = exp_q.pop_front();
                if (word_data !== w.data || word_bytes !== w.bytes ||
                    w_word_data !== w.data || w_word_bytes !== w.bytes) begin
                    miscompares++;
                    $display("[TB] FAIL word: got %h/%0d (twin %h/%0d), required %h/%0d",
                             word_data, word_bytes, w_word_data, w_word_bytes, w.data, w.bytes);
                end
            end
        end
        #1;
        refresh_fifo();
        if (word_valid === 1'b1 && first_valid < 0) first_valid = cycle;
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n = 0;
        while (!(fifo_q.size() == 0 && exp_q.size() == 0 && word_valid === 1'b0 && busy === 1'b0) && n < limit) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= limit) begin
            miscompares++;
            $display("[TB] FAIL %s_timeout: fifo=%0d pending_words=%0d busy=%b, required idle", name, fifo_q.size(), exp_q.size(), busy);
        end
    endtask

    task automatic wait_fifo_empty(input int limit, input string name);
        int n = 0;
        while (fifo_q.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        repeat (3) tick();
        vectors++;
        if (n >= limit) begin
            miscompares++;
            $display("[TB] FAIL %s_timeout: fifo=%0d, required 0", name, fifo_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        fifo_q.push_back(8'hEE);
        refresh_fifo();
        tick();
        vectors += 6;
        if (read_next !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_read_next: got %b, required 0", read_next); end
        if (word_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_word_valid: got %b, required 0", word_valid); end
        if (word_data !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_word_data: got %h, required 0", word_data); end
        if (word_bytes !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_word_bytes: got %0d, required 0", word_bytes); end
        if (words_sent !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_words_sent: got %0d, required 0", words_sent); end
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
        model_reset();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_streaming();
        word_ready = 1'b1;
        pops = 0; first_pop = -1; last_pop = -1; first_valid = -1;
        for (int i = 1; i <= 8; i++) push_byte(8'(i));
        wait_idle(40, "streaming");
        vectors += 3;
        if (pops != 8 || last_pop - first_pop != 7) begin
            miscompares++;
            $display("[TB] FAIL stream_pops: got %0d pops over %0d cycles, required 8 over 8", pops, last_pop - first_pop + 1);
        end
        if (first_valid != first_pop + BPW) begin
            miscompares++;
            $display("[TB] FAIL stream_latency: got valid at %0d, required %0d", first_valid, first_pop + BPW);
        end
        if (words_sent !== 16'd2) begin miscompares++; $display("[TB] FAIL stream_words_sent: got %0d, required 2", words_sent); end
    endtask

    task automatic test_backpressure();
        word_ready = 1'b0;
        pops = 0;
        for (int i = 1; i <= 12; i++) push_byte(8'(i));
        repeat (20) tick();
        vectors += 4;
        if (pops != 8) begin miscompares++; $display("[TB] FAIL bp_pops: got %0d, required 8", pops); end
        if (read_next !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_read_next: got %b, required 0", read_next); end
        if (word_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_word_valid: got %b, required 1", word_valid); end
        if (word_data !== 32'h04030201) begin miscompares++; $display("[TB] FAIL bp_word_data: got %h, required 04030201", word_data); end
        word_ready = 1'b1;
        wait_idle(60, "backpressure");
        vectors++;
        if (words_sent !== 16'(exp_sent)) begin miscompares++; $display("[TB] FAIL bp_words_sent: got %0d, required %0d", words_sent, exp_sent); end
    endtask

    task automatic test_partial_flush();
        word_ready = 1'b1;
        push_byte(8'h0A); push_byte(8'h0B); push_byte(8'h0C);
        wait_fifo_empty(20, "partial_drain");
        vectors += 2;
        if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL partial_busy_before: got %b, required 1", busy); end
        if (word_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL partial_early_word: got %b, required 0", word_valid); end
        flush = 1'b1;
        model_flush();
        tick();
        flush = 1'b0;
        wait_idle(20, "partial_flush");
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL partial_busy_after: got %b, required 0", busy); end
    endtask

    task automatic test_empty_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (5) begin
            tick();
            vectors += 2;
            if (word_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL empty_flush_valid: got %b, required 0", word_valid); end
            if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL empty_flush_busy: got %b, required 0", busy); end
        end
        vectors++;
        if (words_sent !== 16'(exp_sent)) begin miscompares++; $display("[TB] FAIL empty_flush_sent: got %0d, required %0d", words_sent, exp_sent); end
    endtask

    task automatic test_reset_mid_word();
        word_ready = 1'b1;
        push_byte(8'h11); push_byte(8'h12);
        wait_fifo_empty(20, "midword_drain");
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL midword_busy: got %b, required 1", busy); end
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) push_byte(8'h21 + 8'(i));
        tick();
        vectors += 6;
        if (read_next !== 1'b0) begin miscompares++; $display("[TB] FAIL midword_read_next: got %b, required 0", read_next); end
        if (word_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midword_valid: got %b, required 0", word_valid); end
        if (word_data !== 32'h0) begin miscompares++; $display("[TB] FAIL midword_data: got %h, required 0", word_data); end
        if (word_bytes !== 3'd0) begin miscompares++; $display("[TB] FAIL midword_bytes: got %0d, required 0", word_bytes); end
        if (words_sent !== 16'd0) begin miscompares++; $display("[TB] FAIL midword_sent: got %0d, required 0", words_sent); end
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midword_busy_reset: got %b, required 0", busy); end
        reset = 1'b0;
        wait_idle(30, "midword");
    endtask

    task automatic test_random();
        int pushed = 0;
        int n = 0;
        int extra;
        while (pushed < 64 && n < 2000) begin
            word_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                push_byte(8'($urandom));
                pushed++;
            end
            tick();
            n++;
        end
        word_ready = 1'b1;
        wait_idle(200, "random_stream");
        extra = $urandom_range(1, 3);
        for (int i = 0; i < extra; i++) push_byte(8'($urandom));
        wait_fifo_empty(20, "random_tail");
        flush = 1'b1;
        model_flush();
        tick();
        flush = 1'b0;
        wait_idle(30, "random_flush");
        vectors++;
        if (words_sent !== 16'(exp_sent)) begin miscompares++; $display("[TB] FAIL random_sent: got %0d, required %0d", words_sent, exp_sent); end
    endtask

    task automatic test_counter_wrap();
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
        word_ready = 1'b1;
        for (int i = 1; i <= 68; i++) push_byte(8'(i));
        wait_idle(300, "wrap");
        vectors += 3;
        if (words_sent !== 16'd17) begin miscompares++; $display("[TB] FAIL wrap_wide_sent: got %0d, required 17", words_sent); end
        if (w_words_sent !== 4'd1) begin miscompares++; $display("[TB] FAIL wrap_narrow_sent: got %0d, required 1", w_words_sent); end
        if (w_busy !== 1'b0 || w_word_valid !== 1'b0 || w_read_next !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wrap_twin_idle: got busy=%b valid=%b read_next=%b, required 0/0/0", w_busy, w_word_valid, w_read_next);
        end
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        word_ready = 1'b0;
        refresh_fifo();
        test_reset();
        test_streaming();
        test_backpressure();
        test_partial_flush();
        test_empty_flush();
        test_reset_mid_word();
        test_random();
        test_counter_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_word_reader.md
Name: fifo_word_reader

Overview:
- Read-side consumer for the team's cdc_fifo.
- Lives in the read clock domain. Drains bytes from the FIFO's first-word-fall-through read port and packs BYTES_PER_WORD consecutive bytes into one little-endian word.
- Presents each word downstream on a valid/ready handshake. A flush request emits a partial word.
- Sits between cdc_fifo (read_empty/read_next/read_data) and the downstream word consumer.

Parameters:
- DATA_WIDTH, 8, width of one FIFO entry (one lane).
- BYTES_PER_WORD, 4, lanes per output word; legal values are 2 to 8.
- COUNT_WIDTH, 16, width of the emitted-word counter.

Ports:
- clock  input  1  single clock, same as the FIFO read clock.
- reset  input  1  synchronous, active-high.
- read_empty  input  1  FIFO empty flag.
- read_data  input  DATA_WIDTH  FIFO head entry; valid whenever read_empty=0.
- read_next  output  1  pop strobe to the FIFO; combinational.
- flush  input  1  single-cycle request to emit any partially packed word.
- word_data  output  DATA_WIDTH*BYTES_PER_WORD  packed word; lane 0 is the first byte popped, in the LSBs.
- word_bytes  output  $clog2(BYTES_PER_WORD+1)  count of valid lanes in word_data.
- word_valid  output  1  word_data/word_bytes valid.
- word_ready  input  1  downstream accepts the word when word_valid&&word_ready.
- busy  output  1  (lane_count!=0) || word_valid || flush_pending.
- words_sent  output  COUNT_WIDTH  number of accepted words; wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Reset (synchronous, active-high; also applies mid-operation):
  - lane_count=0, accumulator=0, flush_pending=0.
  - word_valid=0, word_data=0, word_bytes=0, words_sent=0, busy=0.
  - read_next=0 whenever reset=1.
  - A partially packed word is discarded on reset.
- Storage: accumulator register (BYTES_PER_WORD lanes) plus lane_count (0..BYTES_PER_WORD), and one output register.
- slot_free = !word_valid || word_ready.
- load = slot_free && (lane_count==BYTES_PER_WORD || (flush_pending && lane_count!=0)).
- read_next = !reset && !read_empty && !flush_pending && (lane_count<BYTES_PER_WORD || load).
  - A pop and a load in the same cycle are allowed; this gives full throughput of one byte per clock.
- Pop: read_data is written into lane lane_count, or into lane 0 if load happens the same cycle. lane_count increments, or becomes 1 on a load+pop cycle.
- Load:
  - word_data is set to the accumulator, with lanes >= lane_count forced to 0.
  - word_bytes is set to lane_count and word_valid to 1.
  - lane_count becomes 0, or 1 if a pop also occurs; accumulator lanes are cleared.
  - flush_pending clears.
- Handshake:
  - word_data and word_bytes hold stable while word_valid=1 and word_ready=0.
  - word_valid falls the cycle after acceptance unless a load occurs in the same cycle.
  - words_sent increments by 1 on each cycle where word_valid&&word_ready.
- Flush:
  - flush=1 with lane_count==0 and no pending flush: no effect; no empty word is ever emitted.
  - flush=1 with lane_count>0: flush_pending is set next cycle, and pops stop until the partial word loads.
  - flush arriving in a cycle where a full-word load occurs: it is satisfied by that load, so flush_pending stays 0.
  - flush while flush_pending=1: ignored.
- Backpressure: with lane_count==BYTES_PER_WORD and slot_free=0, read_next=0 and the FIFO is left untouched.
- Latency: first byte popped at cycle T means the word is visible at word_valid in cycle T+BYTES_PER_WORD, given word_ready=1 throughout.

Test Plan:
- Streaming: FIFO model holds 0x01..0x08, word_ready=1.
  - Required: read_next high 8 consecutive cycles.
  - Words 0x04030201 then 0x08070605, word_bytes=4, words_sent=2.
- Backpressure: word_ready=0 with 12 bytes available.
  - Required: exactly 8 pops, then read_next=0; word_data holds 0x04030201.
  - After raising word_ready, the remaining words 0x08070605 and 0x0C0B0A09 follow in order.
- Partial flush: bytes 0x0A, 0x0B, 0x0C, then FIFO empty and flush pulsed.
  - Required: one word 0x000C0B0A with word_bytes=3, then busy=0.
- Empty flush: flush pulsed with lane_count=0.
  - Required: word_valid stays 0, words_sent unchanged, busy stays 0.
- Reset mid-word: after 2 of 4 bytes, reset held 1 cycle, then bytes 0x21..0x24.
  - Required: all outputs are 0 during reset.
  - Next word is 0x24232221; no stale lanes.
- Counter wrap: COUNT_WIDTH=4, 17 accepted words.
  - Required: words_sent=1.
